// File: rtl/mix_dp_sched_pkg.sv
// Shared constants and types for the mix datapath scheduler.
//   DIN_W / DOUT_W : operand and result widths of the external mix datapath
//   STAT_W         : width of the optional saturating statistics counters
//   sched_state_e  : output-stage (S2) state, IDLE = no result held, HOLD = result held
package mix_dp_sched_pkg;
    localparam int DIN_W  = 10;
    localparam int DOUT_W = 20;
    localparam int STAT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_e;
endpackage

// File: rtl/mix_dp_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i     : request vector
//   ptr_i     : requester with highest priority this cycle (must be < NUM_REQ)
//   en_i      : 0 forces no grant
//   gnt_o     : one-hot grant (all zero when disabled or nothing requested)
//   gnt_idx_o : index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);
    logic            found;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk the requesters starting at the pointer, wrapping at NUM_REQ
    // (which need not be a power of two, hence the explicit subtract).
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end
endmodule

// File: rtl/mix_dp_scheduler.sv
// mix_dp_scheduler: round-robin sharing of one external combinational mix
// datapath among NUM_REQ requesters. S1 registers the granted operand onto
// dp_in; S2 captures dp_out and presents it with the issuing requester ID.
// Latency 2 cycles, throughput 1 per cycle.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   sched_en            : allow new grants (in-flight work always drains)
//   req_valid/req_data  : per-requester operands, requester i at [i*DIN_W +: DIN_W]
//   req_ready           : one-hot accept
//   dp_in / dp_out      : to / from the external datapath
//   resp_valid/data/id  : result handshake, resp_ready from downstream
//   busy                : any stage holds work
// Build option: define MIX_DP_SCHED_STATS_EN to add stat_grants (per-requester
// saturating accept counts) and stat_stall_cnt (saturating output-stall cycles).
module mix_dp_scheduler
    import mix_dp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int DIN_W   = mix_dp_sched_pkg::DIN_W,
    parameter int DOUT_W  = mix_dp_sched_pkg::DOUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sched_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DIN_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DIN_W-1:0]           dp_in,
    input  logic [DOUT_W-1:0]          dp_out,
    output logic                       resp_valid,
    output logic [DOUT_W-1:0]          resp_data,
    output logic [ID_W-1:0]            resp_id,
    input  logic                       resp_ready,
    output logic                       busy
`ifdef MIX_DP_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]  stat_grants,
    output logic [STAT_W-1:0]          stat_stall_cnt
`endif
);
    sched_state_e      state_q, state_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DIN_W-1:0]  dp_in_q, dp_in_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic [DOUT_W-1:0] resp_data_q, resp_data_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic              s2_free, s1_free, grant_en, accept, load_s2;
    logic [ID_W-1:0]   gnt_idx;
    logic [DIN_W-1:0]  sel_data;

    assign resp_valid = (state_q == HOLD);
    assign s2_free    = ~resp_valid | resp_ready;
    assign s1_free    = ~s1_valid_q | s2_free;
    // Reset gating keeps req_ready low while rst is held even if requests are pending.
    assign grant_en   = sched_en & s1_free & ~rst;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .en_i      (grant_en),
        .gnt_o     (req_ready),
        .gnt_idx_o (gnt_idx)
    );

    assign accept = |req_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) sel_data = req_data[i*DIN_W +: DIN_W];
        end
    end

    // S1: dp_in only changes on accept so the datapath input never toggles idle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        dp_in_d    = dp_in_q;
        s1_id_d    = s1_id_q;
        ptr_d      = ptr_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            dp_in_d    = sel_data;
            s1_id_d    = gnt_idx;
            ptr_d      = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (s2_free) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 state machine and result capture.
    always_comb begin
        state_d     = state_q;
        load_s2     = 1'b0;
        case (state_q)
            IDLE: begin
                if (s1_valid_q) begin
                    state_d = HOLD;
                    load_s2 = 1'b1;
                end
            end
            HOLD: begin
                if (resp_ready) begin
                    if (s1_valid_q) begin
                        state_d = HOLD;
                        load_s2 = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        resp_data_d = load_s2 ? dp_out  : resp_data_q;
        resp_id_d   = load_s2 ? s1_id_q : resp_id_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_valid_q  <= 1'b0;
            dp_in_q     <= '0;
            s1_id_q     <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            dp_in_q     <= dp_in_d;
            s1_id_q     <= s1_id_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign dp_in     = dp_in_q;
    assign resp_data = resp_data_q;
    assign resp_id   = resp_id_q;
    assign busy      = s1_valid_q | resp_valid;

`ifdef MIX_DP_SCHED_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q [NUM_REQ];
    logic [STAT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
                end
            end
            if (resp_valid && !resp_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*STAT_W +: STAT_W] = grant_cnt_q[i];
        end
    end
    assign stat_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mix_dp_scheduler.sv
module tb_mix_dp_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DIN_W   = 10;
    localparam int DOUT_W  = 20;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     sched_en;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*DIN_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [DIN_W-1:0]         dp_in;
    logic [DOUT_W-1:0]        dp_out;
    logic                     resp_valid;
    logic [DOUT_W-1:0]        resp_data;
    logic [ID_W-1:0]          resp_id;
    logic                     resp_ready;
    logic                     busy;
`ifdef MIX_DP_SCHED_STATS_EN
    logic [NUM_REQ*16-1:0]    stat_grants;
    logic [15:0]              stat_stall_cnt;
`endif

    // Bench model of the external mix datapath.
    assign dp_out = {10'b0, dp_in};

    mix_dp_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sched_en   (sched_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .dp_in      (dp_in),
        .dp_out     (dp_out),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .busy       (busy)
`ifdef MIX_DP_SCHED_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    logic [ID_W+DOUT_W-1:0] sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, pop on response handshake. Sampled at negedge.
    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready_onehot0", {31'b0, $onehot0(req_ready)}, 32'd1);
            check("req_ready_subset", {28'b0, req_ready & ~req_valid}, 32'd0);
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_resp", {30'b0, resp_id}, 32'hFFFF_FFFF);
                end else begin
                    logic [ID_W+DOUT_W-1:0] exp_e;
                    exp_e = sb_q.pop_front();
                    check("resp_id_order", {30'b0, resp_id}, {30'b0, exp_e[DOUT_W +: ID_W]});
                    check("resp_data", {12'b0, resp_data}, {12'b0, exp_e[DOUT_W-1:0]});
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({ID_W'(i), 10'b0, req_data[i*DIN_W +: DIN_W]});
                    acc_cnt++;
                end
            end
        end
    end

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic               en;
        logic [NUM_REQ-1:0] exp_ready;
    } vec_t;

    task automatic randomize_data();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DIN_W +: DIN_W] = DIN_W'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            req_valid = '0;
        end
    endtask

    initial begin
        vec_t vt [16];
        int   a0;
        logic [DOUT_W-1:0] held;

        // Pointer starts at 1 after the single-request test.
        vt[0]  = '{4'b1000, 1'b1, 4'b1000};
        vt[1]  = '{4'b0001, 1'b1, 4'b0001};
        vt[2]  = '{4'b1111, 1'b1, 4'b0010};
        vt[3]  = '{4'b1111, 1'b1, 4'b0100};
        vt[4]  = '{4'b1111, 1'b1, 4'b1000};
        vt[5]  = '{4'b1111, 1'b1, 4'b0001};
        vt[6]  = '{4'b0000, 1'b1, 4'b0000};
        vt[7]  = '{4'b1111, 1'b0, 4'b0000};
        vt[8]  = '{4'b0001, 1'b1, 4'b0001};
        vt[9]  = '{4'b1001, 1'b1, 4'b1000};
        vt[10] = '{4'b0110, 1'b1, 4'b0010};
        vt[11] = '{4'b1000, 1'b1, 4'b1000};
        vt[12] = '{4'b0100, 1'b1, 4'b0100};
        vt[13] = '{4'b0010, 1'b1, 4'b0010};
        vt[14] = '{4'b1100, 1'b1, 4'b0100};
        vt[15] = '{4'b1010, 1'b1, 4'b1000};

        rst = 1'b1; sched_en = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {28'b0, req_ready}, 32'd0);
        check("rst_dp_in", {22'b0, dp_in}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", {12'b0, resp_data}, 32'd0);
        check("rst_resp_id", {30'b0, resp_id}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request from requester 0: 2-cycle latency.
        @(posedge clk); #1;
        sched_en = 1'b1; resp_ready = 1'b1; req_valid = 4'b0001;
        req_data[0 +: DIN_W] = 10'h155;
        @(negedge clk);
        check("single_ready", {28'b0, req_ready}, 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("single_s1_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("single_dp_in", {22'b0, dp_in}, 32'h155);
        check("single_busy", {31'b0, busy}, 32'd1);
        check("single_ready_after", {28'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("single_resp_valid", {31'b0, resp_valid}, 32'd1);
        check("single_resp_data", {12'b0, resp_data}, 32'h00155);
        check("single_resp_id", {30'b0, resp_id}, 32'd0);
        idle_cycles(2);

        // Grant table with downstream always ready.
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #1;
            req_valid = vt[e].valid; sched_en = vt[e].en; resp_ready = 1'b1;
            randomize_data();
            @(negedge clk);
            check($sformatf("table_ready_%0d", e), {28'b0, req_ready}, {28'b0, vt[e].exp_ready});
        end
        sched_en = 1'b1;
        idle_cycles(4);
        check("table_drained_busy", {31'b0, busy}, 32'd0);

        // Backpressure: 5 cycles with resp_ready low, all valid.
        a0 = acc_cnt;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            req_valid = 4'b1111; resp_ready = 1'b0;
            randomize_data();
            @(negedge clk);
            if (c >= 2) check($sformatf("bp_ready_zero_%0d", c), {28'b0, req_ready}, 32'd0);
            if (c == 2) held = resp_data;
            if (c > 2) check($sformatf("bp_data_stable_%0d", c), {12'b0, resp_data}, {12'b0, held});
        end
        check("bp_accept_count", acc_cnt - a0, 32'd2);
        @(posedge clk); #1;
        req_valid = '0; resp_ready = 1'b1;
        idle_cycles(4);
        check("bp_drained_busy", {31'b0, busy}, 32'd0);

        // Continuous requests: back-to-back responses.
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            req_valid = (c < 5) ? 4'b1111 : 4'b0000;
            randomize_data();
            @(negedge clk);
            check($sformatf("b2b_resp_valid_%0d", c), {31'b0, resp_valid}, {31'b0, (c >= 2)});
        end
        idle_cycles(3);

        // sched_en low after one accept: response still delivered, pointer held.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            sched_en = (c == 0);
            req_valid = (c == 0) ? 4'b0001 : 4'b1111;
            randomize_data();
            @(negedge clk);
            if (c == 0) check("en_first_ready", {28'b0, req_ready}, 32'b0001);
            else        check($sformatf("en_off_ready_%0d", c), {28'b0, req_ready}, 32'd0);
            if (c == 2) check("en_off_resp_valid", {31'b0, resp_valid}, 32'd1);
        end
        @(posedge clk); #1;
        sched_en = 1'b1; req_valid = 4'b1111;
        @(negedge clk);
        check("en_ptr_held", {28'b0, req_ready}, 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        idle_cycles(3);

        // Async reset with both stages full.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            req_valid = 4'b1111; resp_ready = 1'b0;
            randomize_data();
        end
        @(posedge clk); #2;
        check("pre_rst_resp_valid", {31'b0, resp_valid}, 32'd1);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_dp_in", {22'b0, dp_in}, 32'd0);
        check("mid_rst_req_ready", {28'b0, req_ready}, 32'd0);
        req_valid = '0; resp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(2);
        check("post_rst_busy", {31'b0, busy}, 32'd0);

`ifdef MIX_DP_SCHED_STATS_EN
        begin
            logic [15:0] g0, g1, g3;
            g0 = stat_grants[0 +: 16]; g1 = stat_grants[16 +: 16]; g3 = stat_grants[48 +: 16];
            for (int c = 0; c < 70000; c++) begin
                @(posedge clk); #1;
                req_valid = 4'b0100;
            end
            @(posedge clk); #1;
            req_valid = '0;
            idle_cycles(3);
            check("stat_req2_sat", {16'b0, stat_grants[32 +: 16]}, 32'hFFFF);
            check("stat_req0", {16'b0, stat_grants[0 +: 16]}, {16'b0, g0});
            check("stat_req1", {16'b0, stat_grants[16 +: 16]}, {16'b0, g1});
            check("stat_req3", {16'b0, stat_grants[48 +: 16]}, {16'b0, g3});
        end
`endif

        check("sb_empty_at_end", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
